// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Exhaustive self-test engine for an N_IN-input, 1-output combinational gate.
// Walks input combinations 0 .. 2^N_IN-1, holds each for SETTLE cycles,
// samples the gate output into a packed truth table and, when built with
// TT_SWEEPER_CHECK_EN defined, counts bits that differ from an expected table.
//
// Build option:
//   TT_SWEEPER_CHECK_EN  defined   -> mismatch / fail_count are computed
//                        undefined -> mismatch / fail_count tied to 0,
//                                     expected is ignored
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high reset
//   start       request a sweep (sampled only while idle)
//   gate_out    output of the gate under test
//   expected    expected truth table, bit k for input combination k
//   gate_in     drives the gate under test inputs (bit 0 -> in_1)
//   busy        high while a sweep is in progress, including the done cycle
//   done        one-cycle pulse at sweep completion
//   table_out   captured truth table, bit k = gate_out with gate_in == k
//   mismatch    captured table differs from expected
//   fail_count  number of differing table bits
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 gate_out,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      gate_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 mismatch,
  output logic [N_IN:0]        fail_count
);

  localparam int TW = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  // idx carries one extra bit so the last-index compare can never alias
  localparam logic [N_IN:0]   IDX_LAST = (N_IN + 1)'(TW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [N_IN:0]   idx_reg;
  logic [CW-1:0]   cnt_reg;
  logic [TW-1:0]   table_reg;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_SETTLE;
      S_SETTLE:  if (cnt_reg == CNT_LAST) state_next = S_CAPTURE;
      S_CAPTURE: state_next = (idx_reg == IDX_LAST) ? S_DONE : S_SETTLE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // outputs: gate inputs are held through CAPTURE so the sampled value
  // belongs to the combination that was settling
  always_comb begin
    gate_in = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_reg)
      S_SETTLE, S_CAPTURE: begin
        gate_in = idx_reg[N_IN-1:0];
        busy    = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // sweep datapath: index, settle counter and captured table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg   <= '0;
      cnt_reg   <= '0;
      table_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            idx_reg   <= '0;
            cnt_reg   <= '0;
            table_reg <= '0;
          end
        end
        S_SETTLE: cnt_reg <= cnt_reg + 1'b1;
        S_CAPTURE: begin
          table_reg[idx_reg[N_IN-1:0]] <= gate_out;
          if (idx_reg != IDX_LAST) begin
            idx_reg <= idx_reg + 1'b1;
            cnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign table_out = table_reg;

`ifdef TT_SWEEPER_CHECK_EN
  logic          mismatch_reg;
  logic [N_IN:0] fail_reg;

  // compare each captured bit against the expected table as it is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_reg <= 1'b0;
      fail_reg     <= '0;
    end else if (state_reg == S_IDLE && start) begin
      mismatch_reg <= 1'b0;
      fail_reg     <= '0;
    end else if (state_reg == S_CAPTURE &&
                 gate_out != expected[idx_reg[N_IN-1:0]]) begin
      mismatch_reg <= 1'b1;
      fail_reg     <= fail_reg + 1'b1;
    end
  end

  assign mismatch   = mismatch_reg;
  assign fail_count = fail_reg;
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign mismatch        = 1'b0;
  assign fail_count      = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

`ifdef TT_SWEEPER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // AND instance: N_IN=2, SETTLE=1
  logic       a_start = 1'b0;
  logic [3:0] a_expected = 4'b0000;
  logic [1:0] a_gate_in;
  logic       a_gate_out, a_busy, a_done, a_mismatch;
  logic [3:0] a_table;
  logic [2:0] a_fail;
  assign a_gate_out = a_gate_in[0] & a_gate_in[1];

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u_and (
    .clk(clk), .reset(reset), .start(a_start), .gate_out(a_gate_out),
    .expected(a_expected), .gate_in(a_gate_in), .busy(a_busy), .done(a_done),
    .table_out(a_table), .mismatch(a_mismatch), .fail_count(a_fail)
  );

  // Majority instance: N_IN=3, SETTLE=3
  logic       m_start = 1'b0;
  logic [7:0] m_expected = 8'b11101000;
  logic [2:0] m_gate_in;
  logic       m_gate_out, m_busy, m_done, m_mismatch;
  logic [7:0] m_table;
  logic [3:0] m_fail;
  assign m_gate_out = (m_gate_in[0] & m_gate_in[1]) | (m_gate_in[0] & m_gate_in[2]) |
                      (m_gate_in[1] & m_gate_in[2]);

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_maj (
    .clk(clk), .reset(reset), .start(m_start), .gate_out(m_gate_out),
    .expected(m_expected), .gate_in(m_gate_in), .busy(m_busy), .done(m_done),
    .table_out(m_table), .mismatch(m_mismatch), .fail_count(m_fail)
  );

  typedef struct {
    logic [7:0] tbl;
    logic       mm;
    int         fc;
    int         cyc;
  } exp_t;

  exp_t q_and[$];
  exp_t q_maj[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", nm, act, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event, required none (cycle %0d)", nm, cyc);
  endtask

  // scoreboard monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (a_done) begin
      if (q_and.size() == 0) flag("and_unexpected_done");
      else begin
        e = q_and.pop_front();
        chk("and_latency", cyc, e.cyc);
        chk("and_table", {28'd0, a_table}, {24'd0, e.tbl});
        chk("and_mismatch", {31'd0, a_mismatch}, {31'd0, e.mm});
        chk("and_fail_count", {29'd0, a_fail}, e.fc);
        chk("and_busy_in_done", {31'd0, a_busy}, 1);
      end
    end
    if (m_done) begin
      if (q_maj.size() == 0) flag("maj_unexpected_done");
      else begin
        e = q_maj.pop_front();
        chk("maj_latency", cyc, e.cyc);
        chk("maj_table", {24'd0, m_table}, {24'd0, e.tbl});
        chk("maj_mismatch", {31'd0, m_mismatch}, {31'd0, e.mm});
        chk("maj_fail_count", {28'd0, m_fail}, e.fc);
      end
    end
  end

  // raise start on a negedge for the AND instance, optionally queueing the result
  task automatic and_start(input logic [3:0] exp_in, input bit push,
                           input logic [3:0] tbl, input logic mm, input int fc);
    exp_t e;
    @(negedge clk);
    a_expected = exp_in;
    a_start = 1'b1;
    if (push) begin
      e.tbl = {4'd0, tbl}; e.mm = mm; e.fc = fc; e.cyc = cyc + 1 + 8;
      q_and.push_back(e);
    end
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q_and.size() != 0 || q_maj.size() != 0); i++) begin
      @(negedge clk);
      #2;
    end
    if (q_and.size() != 0 || q_maj.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q_and.size() + q_maj.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic and_zero(input string tag);
    chk({tag, "_gate_in"}, {30'd0, a_gate_in}, 0);
    chk({tag, "_busy"}, {31'd0, a_busy}, 0);
    chk({tag, "_done"}, {31'd0, a_done}, 0);
    chk({tag, "_table"}, {28'd0, a_table}, 0);
    chk({tag, "_mismatch"}, {31'd0, a_mismatch}, 0);
    chk({tag, "_fail"}, {29'd0, a_fail}, 0);
  endtask

  initial begin
    exp_t e;
    int c;

    // reset values
    repeat (2) @(negedge clk);
    and_zero("rst_and");
    chk("rst_maj_table", {24'd0, m_table}, 0);
    chk("rst_maj_busy", {31'd0, m_busy}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // AND, matching expected; also walk gate_in through the sweep
    and_start(4'b1000, 1, 4'b1000, 1'b0, 0);
    for (int k = 1; k <= 8; k++) begin
      chk("and_gate_in_step", {30'd0, a_gate_in}, (k - 1) / 2);
      chk("and_busy_step", {31'd0, a_busy}, 1);
      @(negedge clk);
    end
    drain();

    // AND against an XOR table: three bits differ in the check build
    and_start(4'b0110, 1, 4'b1000, CHK, CHK ? 3 : 0);
    drain();

    // majority, 3 inputs, 3 settle cycles: 8*(3+1) = 32 cycles
    @(negedge clk);
    m_start = 1'b1;
    e.tbl = 8'b11101000; e.mm = 1'b0; e.fc = 0; e.cyc = cyc + 1 + 32;
    q_maj.push_back(e);
    @(negedge clk);
    m_start = 1'b0;
    drain();

    // start re-pulsed mid-sweep is ignored
    and_start(4'b1000, 1, 4'b1000, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("repulse_idle_busy", {31'd0, a_busy}, 0);

    // reset at cycle 5 aborts the sweep with no done
    and_start(4'b1111, 0, 4'b0000, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", {31'd0, a_busy}, 1);
    reset = 1'b1;
    #1;
    and_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_still_idle", {31'd0, a_busy}, 0);
    and_start(4'b1000, 1, 4'b1000, 1'b0, 0);
    drain();

    // start held high: two back-to-back sweeps, the second accepted two
    // edges after the first done pulse
    @(negedge clk);
    c = cyc;
    a_expected = 4'b1000;
    a_start = 1'b1;
    e.tbl = 8'b00001000; e.mm = 1'b0; e.fc = 0;
    e.cyc = c + 9;  q_and.push_back(e);
    e.cyc = c + 19; q_and.push_back(e);
    while (cyc < c + 11) @(negedge clk);
    a_start = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised self-test engine for small combinational gate blocks. It walks every input combination of an N-input, 1-output gate under test, waits a configurable settle time, captures the gate's output into a packed truth table, and optionally compares the result against an expected table. It sits in the bench and BIST layer beside the basic gate modules and replaces hand-written exhaustive stimulus sequences.

## Interface
- `N_IN`, default 2: number of gate inputs; legal range 1..6.
- `SETTLE`, default 1: cycles each combination is held before capture; minimum 1.
- `clk` input, 1: sole clock; all state updates on its rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `start` input, 1: request a sweep; sampled only in IDLE.
- `gate_out` input, 1: output of the gate under test.
- `expected` input, 2^N_IN: expected truth table; bit k is the expected output for input combination k.
- `gate_in` output, N_IN: drives the gate under test's inputs; bit 0 maps to `in_1`.
- `busy` output, 1: high from the cycle after start is accepted until DONE is left.
- `done` output, 1: one-cycle pulse when the sweep is complete.
- `table_out` output, 2^N_IN: captured truth table; bit k is `gate_out` sampled with `gate_in == k`.
- `mismatch` output, 1: sweep result differs from `expected` (check build only).
- `fail_count` output, N_IN+1: number of differing table bits (check build only).

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE:
  - `gate_in` = 0 and `busy` = 0.
  - `start` = 1 moves to SETTLE and sets idx = 0, settle count = 0.
  - On the same edge, `table_out`, `mismatch` and `fail_count` clear to 0.
- SETTLE:
  - `gate_in` = idx.
  - The settle count increments each cycle.
  - When the count equals SETTLE-1, the state moves to CAPTURE.
- CAPTURE:
  - `table_out[idx]` <= `gate_out`.
  - If idx = 2^N_IN-1, go to DONE.
  - Otherwise idx increments, the settle count resets to 0, and the state returns to SETTLE.
- DONE:
  - `done` = 1 and `busy` = 1 for this single cycle, then IDLE.
  - `table_out` holds its value until the next accepted start or reset.
- idx is N_IN+1 bits wide internally, so the terminal check never wraps. `gate_in` = idx[N_IN-1:0].
- `start` while busy is ignored. It is not queued.
- `start` held high continuously triggers back-to-back sweeps, one per IDLE visit.

## Timing
- Reset values: state IDLE, `gate_in` 0, `busy` 0, `done` 0, `table_out` 0, `mismatch` 0, `fail_count` 0.
- Cycles per combination: SETTLE+1.
- Let T be the edge that samples `start`. `done` is high in the cycle following edge T + 2^N_IN·(SETTLE+1).
- Example: N_IN=2, SETTLE=1 gives `done` after 8 edges.
- `gate_out` is sampled at the CAPTURE edge, at least SETTLE full cycles after `gate_in` last changed.
- `table_out` bits update one per CAPTURE edge. The full table is valid when `done` = 1.
- Reset mid-sweep:
  - Immediate abort; all outputs take their reset values.
  - `done` never pulses for the aborted sweep.
- Reset and start asserted together: reset wins.

## Configuration
- `TT_SWEEPER_CHECK_EN` defined:
  - On the CAPTURE edge for each index, if `gate_out` != `expected[idx]`, `fail_count` increments and `mismatch` sets.
  - Both are final when `done` = 1 and hold until the next accepted start or reset.
  - `expected` must be stable for the whole sweep.
- `TT_SWEEPER_CHECK_EN` undefined:
  - No comparison logic is built.
  - `mismatch` and `fail_count` are tied to 0.
  - `expected` is unused.

## Test plan
- AND DUT, N_IN=2, SETTLE=1, check build, `expected`=4'b1000, start pulse -> `gate_in` steps 0,1,2,3 every 2 cycles; `done` 8 cycles after start; `table_out`=4'b1000; `mismatch`=0; `fail_count`=0.
- AND DUT, `expected`=4'b0110 (XOR) -> `table_out`=4'b1000; `mismatch`=1; `fail_count`=3.
- Majority DUT, N_IN=3, SETTLE=3 -> `done` 32 cycles after start; `table_out`=8'b11101000.
- `start` re-pulsed at cycle 3 of a sweep -> ignored; a single `done` at cycle 8; no second sweep.
- `reset` at cycle 5 of a sweep -> all outputs 0 immediately; no `done`; a fresh start gives a correct table after 8 cycles.
- Non-check build, mismatching `expected` -> `mismatch`=0 and `fail_count`=0 throughout; `table_out` still correct.
